seg7_radix_scan: RTL



---
 rtl/seg7_pkg.sv | 46 ++++
 rtl/seg7_glyph.sv | 32 +++
 rtl/seg7_radix_scan.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared radix codes, 7-segment glyph constants and FSM state type
// for the radix-selectable scanned display driver.
package seg7_pkg;

  localparam logic [1:0] RADIX_OCT = 2'b00;
  localparam logic [1:0] RADIX_DEC = 2'b01;
  localparam logic [1:0] RADIX_HEX = 2'b10;

  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1111011;
  localparam logic [6:0] SEG_A     = 7'b1110111;
  localparam logic [6:0] SEG_B     = 7'b0011111;
  localparam logic [6:0] SEG_C     = 7'b1001110;
  localparam logic [6:0] SEG_D     = 7'b0111101;
  localparam logic [6:0] SEG_E     = 7'b1001111;
  localparam logic [6:0] SEG_F     = 7'b1000111;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [6:0] SEG_DASH  = 7'b0000001;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DIV    = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  // The reserved code 11 falls through to hex.
  function automatic logic [4:0] base_from_radix(input logic [1:0] radix);
    logic [4:0] base;
    case (radix)
      RADIX_OCT: base = 5'd8;
      RADIX_DEC: base = 5'd10;
      RADIX_HEX: base = 5'd16;
      default:   base = 5'd16;
    endcase
    return base;
  endfunction

endpackage

// File: rtl/seg7_glyph.sv
// Combinational 4-bit digit to 7-segment pattern lookup {a..g}, MSB = a.
module seg7_glyph
  import seg7_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] pattern
);

  // glyph lookup
  always_comb begin
    case (digit)
      4'h0:    pattern = SEG_0;
      4'h1:    pattern = SEG_1;
      4'h2:    pattern = SEG_2;
      4'h3:    pattern = SEG_3;
      4'h4:    pattern = SEG_4;
      4'h5:    pattern = SEG_5;
      4'h6:    pattern = SEG_6;
      4'h7:    pattern = SEG_7;
      4'h8:    pattern = SEG_8;
      4'h9:    pattern = SEG_9;
      4'hA:    pattern = SEG_A;
      4'hB:    pattern = SEG_B;
      4'hC:    pattern = SEG_C;
      4'hD:    pattern = SEG_D;
      4'hE:    pattern = SEG_E;
      4'hF:    pattern = SEG_F;
      default: pattern = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_radix_scan.sv
// Serial radix converter (restoring division, one quotient bit per clock)
// feeding a time-multiplexed 7-segment scanner with blanking and overflow dash.
module seg7_radix_scan
  import seg7_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int NDIG        = 3,
  parameter int REFRESH_DIV = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] data_in,
  input  logic [1:0]        radix,
  input  logic              blank_lz,
  output logic [6:0]        seg,
  output logic [NDIG-1:0]   dig_en,
  output logic              busy,
  output logic              ovf
);

  localparam int SLOT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int BIT_W  = $clog2(DATA_W);
  localparam int CNT_W  = $clog2(REFRESH_DIV);

  state_t            state_r, state_nx;
  logic [DATA_W-1:0] work_r, work_nx;
  logic [4:0]        rem_r, rem_sh, rem_nx, base_r;
  logic [BIT_W-1:0]  bit_r;
  logic [SLOT_W-1:0] k_r, slot_r;
  logic              blank_r, disp_ovf_r, disp_blank_r, busy_r;
  logic [3:0]        shadow_r [NDIG];
  logic [3:0]        bank_r   [NDIG];
  logic [CNT_W-1:0]  cnt_r;
  logic [6:0]        seg_r, seg_nx, glyph_s;
  logic [NDIG-1:0]   dig_en_r, dig_en_nx, lz_s;
  logic              q_bit, last_bit, last_digit, wrap, above_zero;
  logic              do_load, do_step, do_commit;

  assign last_bit   = (bit_r == BIT_W'(DATA_W - 1));
  assign last_digit = (k_r == SLOT_W'(NDIG - 1));
  assign wrap       = (cnt_r == CNT_W'(REFRESH_DIV - 1));

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= S_IDLE;
    else     state_r <= state_nx;
  end

  // FSM next-state logic
  always_comb begin
    state_nx = state_r;
    case (state_r)
      S_IDLE: begin
        if (load) state_nx = S_DIV;
        else      state_nx = S_IDLE;
      end
      S_DIV: begin
        if (last_bit && last_digit) state_nx = S_COMMIT;
        else                        state_nx = S_DIV;
      end
      S_COMMIT: state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  // FSM control strobes
  always_comb begin
    do_load   = 1'b0;
    do_step   = 1'b0;
    do_commit = 1'b0;
    case (state_r)
      S_IDLE:   do_load   = load;
      S_DIV:    do_step   = 1'b1;
      S_COMMIT: do_commit = 1'b1;
      default: begin
        do_load   = 1'b0;
        do_step   = 1'b0;
        do_commit = 1'b0;
      end
    endcase
  end

  // one restoring-division step: shift in the next dividend bit, subtract if it fits
  always_comb begin
    rem_sh  = 5'({rem_r, work_r[DATA_W-1]});
    q_bit   = (rem_sh >= base_r);
    if (q_bit) rem_nx = rem_sh - base_r;
    else       rem_nx = rem_sh;
    work_nx = {work_r[DATA_W-2:0], q_bit};
  end

  // conversion datapath and shadow digits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      work_r  <= '0;
      rem_r   <= 5'd0;
      base_r  <= 5'd0;
      blank_r <= 1'b0;
      bit_r   <= '0;
      k_r     <= '0;
      for (int i = 0; i < NDIG; i++) shadow_r[i] <= 4'd0;
    end else if (do_load) begin
      work_r  <= data_in;
      rem_r   <= 5'd0;
      base_r  <= base_from_radix(radix);
      blank_r <= blank_lz;
      bit_r   <= '0;
      k_r     <= '0;
    end else if (do_step) begin
      work_r <= work_nx;
      if (last_bit) begin
        shadow_r[k_r] <= rem_nx[3:0];
        rem_r <= 5'd0;
        bit_r <= '0;
        k_r   <= last_digit ? SLOT_W'(0) : k_r + SLOT_W'(1);
      end else begin
        rem_r <= rem_nx;
        bit_r <= bit_r + BIT_W'(1);
      end
    end
  end

  // display bank: shadow digits, overflow and blanking mode land together
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NDIG; i++) bank_r[i] <= 4'd0;
      disp_ovf_r   <= 1'b0;
      disp_blank_r <= 1'b0;
    end else if (do_commit) begin
      bank_r       <= shadow_r;
      disp_ovf_r   <= (work_r != '0);
      disp_blank_r <= blank_r;
    end
  end

  // busy flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_r <= 1'b0;
    else     busy_r <= (state_nx != S_IDLE);
  end

  // lz_s[i]: digit i and everything above it is zero; digit 0 never qualifies
  always_comb begin
    above_zero = 1'b1;
    lz_s       = '0;
    for (int i = NDIG - 1; i >= 0; i--) begin
      above_zero = above_zero & (bank_r[i] == 4'd0);
      lz_s[i]    = above_zero & (i != 0);
    end
  end

  seg7_glyph u_glyph (
    .digit   (bank_r[slot_r]),
    .pattern (glyph_s)
  );

  // pattern for the slot being presented at the next wrap
  always_comb begin
    if (disp_ovf_r)                        seg_nx = SEG_DASH;
    else if (disp_blank_r && lz_s[slot_r]) seg_nx = SEG_BLANK;
    else                                   seg_nx = glyph_s;
    dig_en_nx = NDIG'(1) << slot_r;
  end

  // refresh counter, slot index and registered display outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r    <= '0;
      slot_r   <= '0;
      seg_r    <= SEG_BLANK;
      dig_en_r <= '0;
    end else if (wrap) begin
      cnt_r    <= '0;
      slot_r   <= (slot_r == SLOT_W'(NDIG - 1)) ? SLOT_W'(0) : slot_r + SLOT_W'(1);
      seg_r    <= seg_nx;
      dig_en_r <= dig_en_nx;
    end else begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

  assign seg    = seg_r;
  assign dig_en = dig_en_r;
  assign busy   = busy_r;
  assign ovf    = disp_ovf_r;

endmodule
